// File: rtl/dcache_load_arbiter.sv
// Load-port arbiter between the CPU and the prefetcher in front of one wt_dcache load port.
// Pipelines the index/tag handshake and routes in-order rvalids through an ownership FIFO.

package dcache_load_arbiter_pkg;

  localparam int unsigned IndexW = 12;
  localparam int unsigned TagW   = 44;
  localparam int unsigned DataW  = 64;
  localparam int unsigned BeW    = DataW / 8;

  typedef struct packed {
    logic [IndexW-1:0] address_index;
    logic [TagW-1:0]   address_tag;
    logic [DataW-1:0]  data_wdata;
    logic              data_req;
    logic              data_we;
    logic [BeW-1:0]    data_be;
    logic [1:0]        data_size;
    logic              kill_req;
    logic              tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic             data_gnt;
    logic             data_rvalid;
    logic [DataW-1:0] data_rdata;
  } dcache_req_o_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_PF   = 2'd2
  } owner_e;

endpackage

module dcache_load_arbiter
  import dcache_load_arbiter_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned StarveLimit    = 64
) (
  input  logic          clk,
  input  logic          rst_i,
  input  dcache_req_i_t cpu_req_i,
  output dcache_req_o_t cpu_rsp_o,
  input  dcache_req_i_t pf_req_i,
  output dcache_req_o_t pf_rsp_o,
  output dcache_req_i_t cache_req_o,
  input  dcache_req_o_t cache_rsp_i,
  output logic [31:0]   pf_grants_o,
  output logic          rsp_err_o
);

  localparam int unsigned PtrW    = $clog2(MaxOutstanding);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned StarveW = $clog2(StarveLimit + 1);

  // Ownership FIFO: one bit per outstanding load, 1 = prefetcher
  logic [MaxOutstanding-1:0] own_mem_q, own_mem_d;
  logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]           count_q, count_d;
  owner_e                    tag_owner_q, tag_owner_d;
  logic [StarveW-1:0]        starve_q, starve_d;
  logic [31:0]               pf_grants_q, pf_grants_d;
  logic                      rsp_err_q, rsp_err_d;

  logic              pf_win;
  logic              cpu_win;
  logic              fifo_full;
  logic              req_fwd;
  logic              gnt;
  logic              pf_gnt;
  logic              pop;
  logic              fifo_empty;
  logic              head_is_pf;
  logic              tag_valid_sel;
  logic              kill_sel;
  logic [TagW-1:0]   tag_sel;
  logic              kill_eff;
  logic [PtrW-1:0]   wr_addr;

  // Write data and write enable are never used on this load-only port
  logic unused_inputs;
  assign unused_inputs = ^{cpu_req_i.data_wdata, cpu_req_i.data_we,
                           pf_req_i.data_wdata, pf_req_i.data_we};

  // Request-phase winner and grant qualification
  always_comb begin
    fifo_full  = (count_q == CntW'(MaxOutstanding));
    fifo_empty = (count_q == '0);
    pf_win     = pf_req_i.data_req &&
                 (!cpu_req_i.data_req || (starve_q == StarveW'(StarveLimit)));
    cpu_win    = !pf_win && cpu_req_i.data_req;
    req_fwd    = (pf_win || cpu_win) && !fifo_full;
    gnt        = req_fwd && cache_rsp_i.data_gnt;
    pf_gnt     = gnt && pf_win;
    pop        = cache_rsp_i.data_rvalid && !fifo_empty;
    head_is_pf = own_mem_q[rd_ptr_q];
  end

  // Tag-phase source follows the requester granted last cycle
  always_comb begin
    tag_valid_sel = 1'b0;
    kill_sel      = 1'b0;
    tag_sel       = '0;
    unique case (tag_owner_q)
      OWN_CPU: begin
        tag_valid_sel = cpu_req_i.tag_valid;
        kill_sel      = cpu_req_i.kill_req;
        tag_sel       = cpu_req_i.address_tag;
      end
      OWN_PF: begin
        tag_valid_sel = pf_req_i.tag_valid;
        kill_sel      = pf_req_i.kill_req;
        tag_sel       = pf_req_i.address_tag;
      end
      default: ;
    endcase
    // A kill can never remove more entries than remain after the head pop
    kill_eff = tag_valid_sel && kill_sel && (count_q > CntW'(pop));
  end

  // Request towards the cache
  always_comb begin
    cache_req_o = '0;
    if (pf_win) begin
      cache_req_o.address_index = pf_req_i.address_index;
      cache_req_o.data_be       = pf_req_i.data_be;
      cache_req_o.data_size     = pf_req_i.data_size;
    end else if (cpu_win) begin
      cache_req_o.address_index = cpu_req_i.address_index;
      cache_req_o.data_be       = cpu_req_i.data_be;
      cache_req_o.data_size     = cpu_req_i.data_size;
    end
    cache_req_o.data_req    = req_fwd;
    cache_req_o.address_tag = tag_sel;
    cache_req_o.tag_valid   = tag_valid_sel;
    cache_req_o.kill_req    = kill_sel;
  end

  // Grant and response routing back to the requesters
  always_comb begin
    cpu_rsp_o          = '0;
    pf_rsp_o           = '0;
    cpu_rsp_o.data_gnt = gnt && cpu_win;
    pf_rsp_o.data_gnt  = pf_gnt;
    if (pop) begin
      if (head_is_pf) begin
        pf_rsp_o.data_rvalid  = 1'b1;
        pf_rsp_o.data_rdata   = cache_rsp_i.data_rdata;
      end else begin
        cpu_rsp_o.data_rvalid = 1'b1;
        cpu_rsp_o.data_rdata  = cache_rsp_i.data_rdata;
      end
    end
  end

  // Next-state: FIFO, tag owner, starvation and statistics
  always_comb begin
    own_mem_d   = own_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    tag_owner_d = OWN_NONE;
    starve_d    = '0;
    pf_grants_d = pf_grants_q;
    rsp_err_d   = rsp_err_q;

    // A push in the kill cycle overwrites the killed slot instead of advancing
    wr_addr = kill_eff ? (wr_ptr_q - PtrW'(1)) : wr_ptr_q;
    if (gnt) begin
      own_mem_d[wr_addr] = pf_win;
      tag_owner_d        = pf_win ? OWN_PF : OWN_CPU;
    end
    wr_ptr_d = wr_ptr_q + PtrW'(gnt) - PtrW'(kill_eff);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + CntW'(gnt) - CntW'(pop) - CntW'(kill_eff);

    if (pf_req_i.data_req && !pf_gnt) begin
      starve_d = (starve_q == StarveW'(StarveLimit)) ? starve_q : starve_q + StarveW'(1);
    end

    if (pf_gnt && (pf_grants_q != 32'hFFFF_FFFF)) begin
      pf_grants_d = pf_grants_q + 32'd1;
    end

    if (cache_rsp_i.data_rvalid && fifo_empty) begin
      rsp_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      own_mem_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tag_owner_q <= OWN_NONE;
      starve_q    <= '0;
      pf_grants_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      own_mem_q   <= own_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tag_owner_q <= tag_owner_d;
      starve_q    <= starve_d;
      pf_grants_q <= pf_grants_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign pf_grants_o = pf_grants_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dcache_load_arbiter.sv
// Directed bench for dcache_load_arbiter; a negedge monitor scores rvalids against a queue.

module tb_dcache_load_arbiter;
  import dcache_load_arbiter_pkg::*;

  typedef struct {
    logic        is_pf;
    logic [63:0] data;
  } exp_t;

  logic          clk;
  logic          rst;
  dcache_req_i_t cpu_req, pf_req, cache_req;
  dcache_req_o_t cpu_rsp, pf_rsp, cache_rsp;
  logic [31:0]   pf_grants;
  logic          rsp_err;
  logic          gnt_en;
  logic          rvalid_drv;
  logic [63:0]   rdata_drv;

  int   checks;
  int   failures;
  exp_t exp_q[$];

  dcache_load_arbiter #(.MaxOutstanding(4), .StarveLimit(64)) dut (
    .clk        (clk),
    .rst_i      (rst),
    .cpu_req_i  (cpu_req),
    .cpu_rsp_o  (cpu_rsp),
    .pf_req_i   (pf_req),
    .pf_rsp_o   (pf_rsp),
    .cache_req_o(cache_req),
    .cache_rsp_i(cache_rsp),
    .pf_grants_o(pf_grants),
    .rsp_err_o  (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache model: grants whatever is presented, rvalid/rdata are directed
  always_comb begin
    cache_rsp             = '0;
    cache_rsp.data_gnt    = gnt_en & cache_req.data_req;
    cache_rsp.data_rvalid = rvalid_drv;
    cache_rsp.data_rdata  = rdata_drv;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input logic is_pf, input logic [63:0] data);
    exp_t e;
    e.is_pf = is_pf;
    e.data  = data;
    exp_q.push_back(e);
  endtask

  task automatic drive_rvalid(input logic v, input logic [63:0] d);
    rvalid_drv = v;
    rdata_drv  = v ? d : 64'd0;
  endtask

  task automatic idle_inputs();
    cpu_req = '0;
    pf_req  = '0;
    drive_rvalid(1'b0, 64'd0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_pf_grants", 64'(pf_grants), 64'd0);
    chk("rst_err", 64'(rsp_err), 64'd0);
    chk("rst_cache_req", 64'(cache_req.data_req), 64'd0);
    chk("rst_tag_valid", 64'(cache_req.tag_valid), 64'd0);
    chk("rst_rsp_bits", 64'({cpu_rsp.data_gnt, cpu_rsp.data_rvalid, pf_rsp.data_gnt, pf_rsp.data_rvalid}), 64'd0);
    chk("rst_count", 64'(dut.count_q), 64'd0);
  endtask

  // Scoreboard monitor: every rvalid presented must match the queue head
  always @(negedge clk) begin
    if (!rst && (cpu_rsp.data_rvalid || pf_rsp.data_rvalid)) begin
      if (exp_q.size() == 0) begin
        chk("rvalid_unexpected", 64'({cpu_rsp.data_rvalid, pf_rsp.data_rvalid}), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_pf_rvalid", 64'(pf_rsp.data_rvalid), 64'(e.is_pf));
        chk("rsp_cpu_rvalid", 64'(cpu_rsp.data_rvalid), 64'(!e.is_pf));
        chk("rsp_rdata", e.is_pf ? pf_rsp.data_rdata : cpu_rsp.data_rdata, e.data);
        chk("rsp_silent_rdata", e.is_pf ? cpu_rsp.data_rdata : pf_rsp.data_rdata, 64'd0);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    gnt_en   = 1'b1;
    rst      = 1'b1;
    idle_inputs();
    do_reset();

    // CPU only: three back-to-back loads, rvalid two cycles after each grant
    step();
    cpu_req.data_req = 1'b1; cpu_req.address_index = 12'h010;
    cpu_req.data_be = 8'hFF; cpu_req.data_size = 2'd3;
    #1;
    chk("t1_cpu_gnt", 64'(cpu_rsp.data_gnt), 64'd1);
    chk("t1_pf_gnt", 64'(pf_rsp.data_gnt), 64'd0);
    chk("t1_index", 64'(cache_req.address_index), 64'h010);
    step();
    cpu_req.tag_valid = 1'b1; cpu_req.address_tag = 44'h100; cpu_req.address_index = 12'h018;
    step();
    cpu_req.address_tag = 44'h101; cpu_req.address_index = 12'h020;
    drive_rvalid(1'b1, 64'hA); expect_rsp(1'b0, 64'hA);
    step();
    cpu_req.data_req = 1'b0; cpu_req.address_tag = 44'h102;
    drive_rvalid(1'b1, 64'hB); expect_rsp(1'b0, 64'hB);
    step();
    cpu_req.tag_valid = 1'b0;
    drive_rvalid(1'b1, 64'hC); expect_rsp(1'b0, 64'hC);
    step();
    drive_rvalid(1'b0, 64'd0);
    #1;
    chk("t1_fifo_empty", 64'(dut.count_q), 64'd0);

    // Interleave: pf tag phase overlaps the CPU request phase
    step();
    pf_req.data_req = 1'b1; pf_req.address_index = 12'h030;
    #1;
    chk("t2_pf_gnt", 64'(pf_rsp.data_gnt), 64'd1);
    step();
    pf_req.data_req = 1'b0; pf_req.tag_valid = 1'b1; pf_req.address_tag = 44'h111;
    cpu_req.data_req = 1'b1; cpu_req.address_index = 12'h040;
    #1;
    chk("t2_tag_valid", 64'(cache_req.tag_valid), 64'd1);
    chk("t2_tag", 64'(cache_req.address_tag), 64'h111);
    chk("t2_index", 64'(cache_req.address_index), 64'h040);
    chk("t2_data_req", 64'(cache_req.data_req), 64'd1);
    chk("t2_cpu_gnt", 64'(cpu_rsp.data_gnt), 64'd1);
    step();
    pf_req.tag_valid = 1'b0;
    cpu_req.data_req = 1'b0; cpu_req.tag_valid = 1'b1; cpu_req.address_tag = 44'h222;
    drive_rvalid(1'b1, 64'h55); expect_rsp(1'b1, 64'h55);
    step();
    cpu_req.tag_valid = 1'b0;
    drive_rvalid(1'b1, 64'h66); expect_rsp(1'b0, 64'h66);
    step();
    drive_rvalid(1'b0, 64'd0);

    // Starvation: pf pending against a continuous CPU stream wins on its 65th cycle
    do_reset();
    for (int i = 1; i <= 65; i++) begin
      step();
      cpu_req.data_req = 1'b1; cpu_req.address_index = 12'h050;
      cpu_req.tag_valid = 1'b1; cpu_req.address_tag = 44'h333;
      pf_req.data_req = 1'b1; pf_req.address_index = 12'h060;
      if (i >= 3) begin
        drive_rvalid(1'b1, 64'h100 + 64'(i - 2));
        expect_rsp(1'b0, 64'h100 + 64'(i - 2));
      end
      #1;
      chk("t3_pf_gnt", 64'(pf_rsp.data_gnt), 64'(i == 65));
    end
    step();
    cpu_req = '0;
    pf_req.data_req = 1'b0; pf_req.tag_valid = 1'b1; pf_req.address_tag = 44'h444;
    drive_rvalid(1'b1, 64'h100 + 64'd64); expect_rsp(1'b0, 64'h100 + 64'd64);
    #1;
    chk("t3_pf_grants", 64'(pf_grants), 64'd1);
    chk("t3_starve_cnt", 64'(dut.starve_q), 64'd0);
    step();
    pf_req.tag_valid = 1'b0;
    drive_rvalid(1'b1, 64'h100 + 64'd65); expect_rsp(1'b1, 64'h100 + 64'd65);
    step();
    drive_rvalid(1'b0, 64'd0);
    #1;
    chk("t3_fifo_empty", 64'(dut.count_q), 64'd0);

    // Full: four outstanding grants block the fifth, a same-cycle pop does not unblock
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      step();
      cpu_req.data_req = 1'b1; cpu_req.address_index = 12'(8 * i);
      cpu_req.tag_valid = (i > 1); cpu_req.address_tag = 44'(i);
    end
    step();
    cpu_req.address_index = 12'h0F0;
    drive_rvalid(1'b1, 64'h1); expect_rsp(1'b0, 64'h1);
    #1;
    chk("t4_full_data_req", 64'(cache_req.data_req), 64'd0);
    chk("t4_full_gnt", 64'(cpu_rsp.data_gnt), 64'd0);
    step();
    drive_rvalid(1'b1, 64'h2); expect_rsp(1'b0, 64'h2);
    #1;
    chk("t4_unblock_data_req", 64'(cache_req.data_req), 64'd1);
    chk("t4_unblock_gnt", 64'(cpu_rsp.data_gnt), 64'd1);
    step();
    cpu_req.data_req = 1'b0;
    drive_rvalid(1'b1, 64'h3); expect_rsp(1'b0, 64'h3);
    step();
    cpu_req.tag_valid = 1'b0;
    drive_rvalid(1'b1, 64'h4); expect_rsp(1'b0, 64'h4);
    step();
    drive_rvalid(1'b1, 64'h5); expect_rsp(1'b0, 64'h5);
    step();
    drive_rvalid(1'b0, 64'd0);
    #1;
    chk("t4_fifo_empty", 64'(dut.count_q), 64'd0);

    // Kill: killed CPU load leaves no entry, following pf rvalid routes to pf
    step();
    cpu_req.data_req = 1'b1; cpu_req.address_index = 12'h070;
    step();
    cpu_req.data_req = 1'b0; cpu_req.tag_valid = 1'b1; cpu_req.kill_req = 1'b1;
    step();
    cpu_req = '0;
    #1;
    chk("t5_count_after_kill", 64'(dut.count_q), 64'd0);
    pf_req.data_req = 1'b1; pf_req.address_index = 12'h080;
    step();
    pf_req.data_req = 1'b0; pf_req.tag_valid = 1'b1; pf_req.address_tag = 44'h555;
    step();
    pf_req.tag_valid = 1'b0;
    drive_rvalid(1'b1, 64'h77); expect_rsp(1'b1, 64'h77);
    step();
    drive_rvalid(1'b0, 64'd0);

    // Error: rvalid with nothing outstanding is dropped and sticky
    step();
    drive_rvalid(1'b1, 64'hDEAD);
    step();
    drive_rvalid(1'b0, 64'd0);
    #1;
    chk("t6_err_set", 64'(rsp_err), 64'd1);
    step();
    step();
    chk("t6_err_held", 64'(rsp_err), 64'd1);

    // Reset with two loads outstanding clears everything immediately
    step();
    cpu_req.data_req = 1'b1; cpu_req.address_index = 12'h090;
    step();
    cpu_req.tag_valid = 1'b1; cpu_req.address_index = 12'h098;
    step();
    cpu_req.data_req = 1'b0;
    #2;
    rst = 1'b1;
    cpu_req = '0;
    #1;
    chk("t6_rst_err", 64'(rsp_err), 64'd0);
    chk("t6_rst_count", 64'(dut.count_q), 64'd0);
    chk("t6_rst_owner", 64'(dut.tag_owner_q), 64'd0);
    chk("t6_rst_outputs", 64'({cache_req.data_req, cache_req.tag_valid, cpu_rsp.data_gnt, cpu_rsp.data_rvalid}), 64'd0);
    step();
    rst = 1'b0;
    step();
    drive_rvalid(1'b1, 64'hBEEF);
    step();
    drive_rvalid(1'b0, 64'd0);
    #1;
    chk("t6_late_rvalid_err", 64'(rsp_err), 64'd1);
    step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
